// File: rtl/cfg_image_sequencer.sv
// ---------------------------------------------------------------------------
// cfg_image_sequencer
//
// Configuration sequencer for the ML555 CPLD. After a board reset it holds the
// ICS874003-02 clock synthesizer in reset. It then latches the jumper-selected
// Platform Flash image and pulses PROG_B low. INIT_B and DONE are supervised
// with timeouts. A failed attempt falls back to the golden image 0 for a
// limited number of retries before parking in ERROR. A debounced press of the
// PROG pushbutton restarts the sequence from any state except ICS_RST.
//
// Ports
//   CLK                  in   board clock, rising edge
//   RST                  in   synchronous active-high reset
//   PROG_SW_B            in   raw PROG pushbutton, active low, asynchronous
//   MAN_AUTO             in   1 forces FLASH_SEL[0] to 0 (sampled live)
//   FLASH_IMAGE0_SELECT  in   header image bit 0 (revision select)
//   FLASH_IMAGE1_SELECT  in   header image bit 1 (flash device select)
//   INIT_B               in   FPGA INIT_B, asynchronous
//   FPGA_DONE            in   FPGA DONE, asynchronous
//   PROG_B               out  FPGA PROG_B, active low
//   FLASH_CF_B           out  copy of PROG_B for the Platform Flash
//   FLASH_SEL[1:0]       out  Platform Flash revision select, bit 1 tied low
//   FLASH_CE_B           out  flash 0 chip enable, active low
//   FLASH_CE1_B          out  flash 1 chip enable, active low
//   ICS_MR               out  clock synthesizer master reset, active high
//   CFG_STATE[2:0]       out  current state code
//   CFG_ERR              out  high while in ERROR
//   RETRY_CNT[1:0]       out  golden-image retries used in this sequence
// ---------------------------------------------------------------------------
module cfg_image_sequencer #(
    parameter int ICS_RST_CYCLES    = 4096,
    parameter int PROG_PULSE_CYCLES = 1024,
    parameter int INIT_TIMEOUT      = 65536,
    parameter int DONE_TIMEOUT      = 16777216,
    parameter int DEBOUNCE_CYCLES   = 65536,
    parameter int MAX_RETRY         = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PROG_SW_B,
    input  logic       MAN_AUTO,
    input  logic       FLASH_IMAGE0_SELECT,
    input  logic       FLASH_IMAGE1_SELECT,
    input  logic       INIT_B,
    input  logic       FPGA_DONE,
    output logic       PROG_B,
    output logic       FLASH_CF_B,
    output logic [1:0] FLASH_SEL,
    output logic       FLASH_CE_B,
    output logic       FLASH_CE1_B,
    output logic       ICS_MR,
    output logic [2:0] CFG_STATE,
    output logic       CFG_ERR,
    output logic [1:0] RETRY_CNT
);

    // -----------------------------------------------------------------------
    // Counter sizing: the shared state counter must reach the largest
    // terminal count of any state.
    // -----------------------------------------------------------------------
    localparam int MAX_AB  = (ICS_RST_CYCLES > PROG_PULSE_CYCLES) ? ICS_RST_CYCLES : PROG_PULSE_CYCLES;
    localparam int MAX_CD  = (INIT_TIMEOUT > DONE_TIMEOUT) ? INIT_TIMEOUT : DONE_TIMEOUT;
    localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CNT_W-1:0] ICS_LAST   = CNT_W'(ICS_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] PROG_LAST  = CNT_W'(PROG_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DONE_LAST  = CNT_W'(DONE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};
    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_ICS_RST    = 3'd0,
        ST_PROG       = 3'd1,
        ST_WAIT_INIT  = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_CONFIGURED = 3'd4,
        ST_ERROR      = 3'd5
    } state_t;

    // -----------------------------------------------------------------------
    // Two-flop synchronizers for the asynchronous inputs.
    // Bit 0 = INIT_B, bit 1 = FPGA_DONE, bit 2 = PROG_SW_B.
    // The button idles high, so its synchronizer resets to 1 to avoid a
    // phantom low period right after reset.
    // -----------------------------------------------------------------------
    localparam int               NSYNC        = 3;
    localparam logic [NSYNC-1:0] SYNC_RST_VAL = 3'b100;

    logic [NSYNC-1:0] async_in;
    logic [NSYNC-1:0] sync_vec;

    assign async_in = {PROG_SW_B, FPGA_DONE, INIT_B};

    genvar gi;
    generate
        for (gi = 0; gi < NSYNC; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    meta_reg <= SYNC_RST_VAL[gi];
                    sync_reg <= SYNC_RST_VAL[gi];
                end else begin
                    meta_reg <= async_in[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign sync_vec[gi] = sync_reg;
        end
    endgenerate

    logic init_sync;
    logic done_sync;
    logic sw_sync;

    assign init_sync = sync_vec[0];
    assign done_sync = sync_vec[1];
    assign sw_sync   = sync_vec[2];

    // -----------------------------------------------------------------------
    // Pushbutton debounce. The press event fires on the DEBOUNCE_CYCLES-th
    // consecutive low sample; armed_reg then blocks further events until the
    // button has been seen released.
    // -----------------------------------------------------------------------
    logic [DEB_W-1:0] deb_cnt_reg;
    logic             armed_reg;
    logic             press;

    assign press = armed_reg && !sw_sync && (deb_cnt_reg == DEB_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            deb_cnt_reg <= '0;
            armed_reg   <= 1'b1;
        end else if (sw_sync) begin
            deb_cnt_reg <= '0;
            armed_reg   <= 1'b1;
        end else begin
            if (deb_cnt_reg != DEB_LAST) begin
                deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
            end
            if (press) begin
                armed_reg <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Sequencer state
    // -----------------------------------------------------------------------
    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       retry_reg;
    logic [1:0]       retry_next;
    logic [1:0]       image_reg;
    logic [1:0]       image_next;
    logic             enter;      // entering a state (including re-entry of PROG)
    logic             fail;       // attempt failed this cycle
    logic             can_retry;

    assign can_retry = (int'(retry_reg) < MAX_RETRY) && (retry_reg != 2'b11);

    always_comb begin
        state_next = state_reg;
        retry_next = retry_reg;
        image_next = image_reg;
        enter      = 1'b0;
        fail       = 1'b0;

        case (state_reg)
            ST_ICS_RST: begin
                if (cnt_reg == ICS_LAST) begin
                    state_next = ST_PROG;
                    image_next = {FLASH_IMAGE1_SELECT, FLASH_IMAGE0_SELECT};
                    enter      = 1'b1;
                end
            end
            ST_PROG: begin
                if (cnt_reg == PROG_LAST) begin
                    state_next = ST_WAIT_INIT;
                    enter      = 1'b1;
                end
            end
            ST_WAIT_INIT: begin
                if (init_sync) begin
                    state_next = ST_WAIT_DONE;
                    enter      = 1'b1;
                end else if (cnt_reg == INIT_LAST) begin
                    fail = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                // DONE is checked first so a simultaneous INIT_B drop still
                // counts as a successful configuration.
                if (done_sync) begin
                    state_next = ST_CONFIGURED;
                    enter      = 1'b1;
                end else if (!init_sync) begin
                    fail = 1'b1;
                end else if (cnt_reg == DONE_LAST) begin
                    fail = 1'b1;
                end
            end
            ST_CONFIGURED: begin
                // DONE falling is deliberately ignored here.
                state_next = ST_CONFIGURED;
            end
            ST_ERROR: begin
                state_next = ST_ERROR;
            end
            default: begin
                state_next = ST_ICS_RST;
                enter      = 1'b1;
            end
        endcase

        // Failed attempt: fall back to the golden image while retries remain.
        if (fail) begin
            enter = 1'b1;
            if (can_retry) begin
                retry_next = retry_reg + 2'd1;
                image_next = 2'b00;
                state_next = ST_PROG;
            end else begin
                state_next = ST_ERROR;
            end
        end

        // A button press overrides everything except the clock reset phase.
        if (press && (state_reg != ST_ICS_RST)) begin
            state_next = ST_PROG;
            retry_next = 2'b00;
            image_next = {FLASH_IMAGE1_SELECT, FLASH_IMAGE0_SELECT};
            enter      = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_ICS_RST;
            cnt_reg   <= '0;
            retry_reg <= 2'b00;
            image_reg <= 2'b00;
        end else begin
            state_reg <= state_next;
            retry_reg <= retry_next;
            image_reg <= image_next;
            if (enter) begin
                cnt_reg <= '0;
            end else if (cnt_reg != CNT_SAT) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output decode. Outputs are computed from the next-state values and
    // registered, so every pin changes on the same edge as CFG_STATE.
    // -----------------------------------------------------------------------
    logic ics_mr_next;
    logic prog_b_next;
    logic flash_active;
    logic ce_b_next;
    logic ce1_b_next;
    logic sel0_next;
    logic err_next;

    always_comb begin
        ics_mr_next  = (state_next == ST_ICS_RST);
        prog_b_next  = (state_next == ST_WAIT_INIT) || (state_next == ST_WAIT_DONE) ||
                       (state_next == ST_CONFIGURED) || (state_next == ST_ERROR);
        flash_active = (state_next == ST_PROG) || (state_next == ST_WAIT_INIT) ||
                       (state_next == ST_WAIT_DONE);
        ce_b_next    = !(flash_active && !image_next[1]);
        ce1_b_next   = !(flash_active && image_next[1]);
        sel0_next    = !MAN_AUTO && image_next[0];
        err_next     = (state_next == ST_ERROR);
    end

    logic ics_mr_reg;
    logic prog_b_reg;
    logic ce_b_reg;
    logic ce1_b_reg;
    logic sel0_reg;
    logic err_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ics_mr_reg <= 1'b1;
            prog_b_reg <= 1'b0;
            ce_b_reg   <= 1'b1;
            ce1_b_reg  <= 1'b1;
            sel0_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            ics_mr_reg <= ics_mr_next;
            prog_b_reg <= prog_b_next;
            ce_b_reg   <= ce_b_next;
            ce1_b_reg  <= ce1_b_next;
            sel0_reg   <= sel0_next;
            err_reg    <= err_next;
        end
    end

    assign ICS_MR      = ics_mr_reg;
    assign PROG_B      = prog_b_reg;
    assign FLASH_CF_B  = prog_b_reg;
    assign FLASH_CE_B  = ce_b_reg;
    assign FLASH_CE1_B = ce1_b_reg;
    assign FLASH_SEL   = {1'b0, sel0_reg};
    assign CFG_ERR     = err_reg;
    assign CFG_STATE   = state_reg;
    assign RETRY_CNT   = retry_reg;

endmodule

// File: tb/tb_cfg_image_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cfg_image_sequencer
//
// Directed and randomized bench for cfg_image_sequencer with small timing
// parameters. Expected behaviour comes from a model of the sequence at the
// attempt level: durations per state, retry bookkeeping, latched image and
// the resulting flash enables/selects.
// ---------------------------------------------------------------------------
module tb_cfg_image_sequencer;

    localparam int ICS_RST_CYCLES    = 16;
    localparam int PROG_PULSE_CYCLES = 8;
    localparam int INIT_TIMEOUT      = 32;
    localparam int DONE_TIMEOUT      = 64;
    localparam int DEBOUNCE_CYCLES   = 4;
    localparam int MAX_RETRY         = 1;

    localparam logic [2:0] S_ICS   = 3'd0;
    localparam logic [2:0] S_PROG  = 3'd1;
    localparam logic [2:0] S_WINIT = 3'd2;
    localparam logic [2:0] S_WDONE = 3'd3;
    localparam logic [2:0] S_CONF  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    // Attempt scenarios
    localparam int M_OK      = 0;   // INIT then DONE
    localparam int M_INIT_TO = 1;   // INIT_B never rises
    localparam int M_CRC     = 2;   // INIT_B drops in WAIT_DONE
    localparam int M_DONE_TO = 3;   // DONE never rises
    localparam int M_RESET   = 4;   // RST pulsed during WAIT_DONE
    localparam int M_TIE     = 5;   // DONE rises as INIT_B drops

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       PROG_SW_B = 1'b1;
    logic       MAN_AUTO = 1'b0;
    logic       FLASH_IMAGE0_SELECT = 1'b0;
    logic       FLASH_IMAGE1_SELECT = 1'b0;
    logic       INIT_B = 1'b0;
    logic       FPGA_DONE = 1'b0;
    logic       PROG_B;
    logic       FLASH_CF_B;
    logic [1:0] FLASH_SEL;
    logic       FLASH_CE_B;
    logic       FLASH_CE1_B;
    logic       ICS_MR;
    logic [2:0] CFG_STATE;
    logic       CFG_ERR;
    logic [1:0] RETRY_CNT;

    int checks   = 0;
    int failures = 0;

    // Reference model of the sequence
    logic [1:0] model_img;
    int         model_retry;
    logic [2:0] model_state;

    cfg_image_sequencer #(
        .ICS_RST_CYCLES   (ICS_RST_CYCLES),
        .PROG_PULSE_CYCLES(PROG_PULSE_CYCLES),
        .INIT_TIMEOUT     (INIT_TIMEOUT),
        .DONE_TIMEOUT     (DONE_TIMEOUT),
        .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
        .MAX_RETRY        (MAX_RETRY)
    ) dut (
        .CLK                (CLK),
        .RST                (RST),
        .PROG_SW_B          (PROG_SW_B),
        .MAN_AUTO           (MAN_AUTO),
        .FLASH_IMAGE0_SELECT(FLASH_IMAGE0_SELECT),
        .FLASH_IMAGE1_SELECT(FLASH_IMAGE1_SELECT),
        .INIT_B             (INIT_B),
        .FPGA_DONE          (FPGA_DONE),
        .PROG_B             (PROG_B),
        .FLASH_CF_B         (FLASH_CF_B),
        .FLASH_SEL          (FLASH_SEL),
        .FLASH_CE_B         (FLASH_CE_B),
        .FLASH_CE1_B        (FLASH_CE1_B),
        .ICS_MR             (ICS_MR),
        .CFG_STATE          (CFG_STATE),
        .CFG_ERR            (CFG_ERR),
        .RETRY_CNT          (RETRY_CNT)
    );

    always #5 CLK = ~CLK;

    // Advance one cycle; samples and drives happen 1 ns after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] cur_hdr();
        return {FLASH_IMAGE1_SELECT, FLASH_IMAGE0_SELECT};
    endfunction

    task automatic set_hdr(input logic [1:0] h);
        FLASH_IMAGE1_SELECT = h[1];
        FLASH_IMAGE0_SELECT = h[0];
    endtask

    // Flash pins while an attempt is active, from the model's latched image.
    task automatic check_flash(input string tag);
        check({tag, "_ce_b"},  32'(FLASH_CE_B),  32'(model_img[1]));
        check({tag, "_ce1_b"}, 32'(FLASH_CE1_B), 32'(!model_img[1]));
        check({tag, "_sel"},   32'(FLASH_SEL),   32'({1'b0, (MAN_AUTO ? 1'b0 : model_img[0])}));
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
        int n;
        n = 0;
        while (CFG_STATE !== st && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_reached"}, 32'(CFG_STATE), 32'(st));
    endtask

    // Reset for 'hold' cycles, check reset values, then measure ICS_MR.
    task automatic do_reset(input int hold);
        int n;
        RST       = 1'b1;
        INIT_B    = 1'b0;
        FPGA_DONE = 1'b0;
        PROG_SW_B = 1'b1;
        repeat (hold) tick();
        check("rst_ics_mr", 32'(ICS_MR),      32'd1);
        check("rst_prog_b", 32'(PROG_B),      32'd0);
        check("rst_cf_b",   32'(FLASH_CF_B),  32'd0);
        check("rst_ce_b",   32'(FLASH_CE_B),  32'd1);
        check("rst_ce1_b",  32'(FLASH_CE1_B), 32'd1);
        check("rst_sel",    32'(FLASH_SEL),   32'd0);
        check("rst_err",    32'(CFG_ERR),     32'd0);
        check("rst_state",  32'(CFG_STATE),   32'(S_ICS));
        check("rst_retry",  32'(RETRY_CNT),   32'd0);
        RST = 1'b0;
        n = 0;
        while (ICS_MR === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check("ics_mr_len", 32'(n), 32'(ICS_RST_CYCLES));
        model_img   = cur_hdr();
        model_retry = 0;
        model_state = S_PROG;
    endtask

    // Hold the button low for 'len' cycles. INIT_B/DONE are cleared as the
    // FPGA would once it is reprogrammed.
    task automatic press(input int len);
        INIT_B    = 1'b0;
        FPGA_DONE = 1'b0;
        PROG_SW_B = 1'b0;
        repeat (len) tick();
        PROG_SW_B = 1'b1;
        if (len >= DEBOUNCE_CYCLES && model_state != S_ICS) begin
            model_state = S_PROG;
            model_retry = 0;
            model_img   = cur_hdr();
        end
    endtask

    // Model of a failed attempt, then compare against the pins.
    task automatic attempt_failed(input string tag);
        INIT_B    = 1'b0;
        FPGA_DONE = 1'b0;
        if (model_retry < MAX_RETRY) begin
            model_retry++;
            model_img   = 2'b00;
            model_state = S_PROG;
            check({tag, "_retry_state"}, 32'(CFG_STATE), 32'(S_PROG));
            check({tag, "_retry_cnt"},   32'(RETRY_CNT), 32'(model_retry));
        end else begin
            model_state = S_ERR;
            check({tag, "_err_state"}, 32'(CFG_STATE),   32'(S_ERR));
            check({tag, "_err_flag"},  32'(CFG_ERR),     32'd1);
            check({tag, "_err_prog_b"},32'(PROG_B),      32'd1);
            check({tag, "_err_ce_b"},  32'(FLASH_CE_B),  32'd1);
            check({tag, "_err_ce1_b"}, 32'(FLASH_CE1_B), 32'd1);
            check({tag, "_err_retry"}, 32'(RETRY_CNT),   32'(model_retry));
        end
    endtask

    // One configuration attempt starting from (or just before) PROG.
    task automatic run_attempt(input int mode, input int d_init, input int d_done);
        int n;
        wait_state(S_PROG, 40, "prog_start");
        check("prog_prog_b", 32'(PROG_B),     32'd0);
        check("prog_cf_b",   32'(FLASH_CF_B), 32'd0);
        check("prog_ics_mr", 32'(ICS_MR),     32'd0);
        check("prog_retry",  32'(RETRY_CNT),  32'(model_retry));
        check_flash("prog");
        n = 0;
        while (CFG_STATE === S_PROG && n < 100) begin
            n++;
            tick();
        end
        check("prog_len", 32'(n), 32'(PROG_PULSE_CYCLES));

        check("winit_state", 32'(CFG_STATE),  32'(S_WINIT));
        check("winit_prog_b",32'(PROG_B),     32'd1);
        check("winit_cf_b",  32'(FLASH_CF_B), 32'd1);
        // Header changes during an attempt must not affect the latched image.
        set_hdr(2'($urandom_range(3, 0)));

        n = 0;
        while (CFG_STATE === S_WINIT && n < 200) begin
            if (mode != M_INIT_TO && n == d_init) INIT_B = 1'b1;
            n++;
            tick();
        end
        if (mode == M_INIT_TO) begin
            check("winit_timeout_len", 32'(n), 32'(INIT_TIMEOUT));
            attempt_failed("init_to");
            return;
        end
        // Two synchronizer stages plus the registered decision.
        check("winit_len", 32'(n), 32'(d_init + 3));
        check("wdone_state", 32'(CFG_STATE), 32'(S_WDONE));
        check_flash("wdone");

        if (mode == M_RESET) begin
            repeat (d_done) tick();
            do_reset(1);
            return;
        end

        n = 0;
        while (CFG_STATE === S_WDONE && n < 200) begin
            if (n == d_done) begin
                if (mode == M_OK || mode == M_TIE) FPGA_DONE = 1'b1;
                if (mode == M_CRC || mode == M_TIE) INIT_B = 1'b0;
            end
            n++;
            tick();
        end
        if (mode == M_DONE_TO) begin
            check("wdone_timeout_len", 32'(n), 32'(DONE_TIMEOUT));
            attempt_failed("done_to");
        end else if (mode == M_CRC) begin
            check("crc_len", 32'(n), 32'(d_done + 3));
            attempt_failed("crc");
        end else begin
            check("wdone_len", 32'(n), 32'(d_done + 3));
            model_state = S_CONF;
            check("conf_state",  32'(CFG_STATE),   32'(S_CONF));
            check("conf_ce_b",   32'(FLASH_CE_B),  32'd1);
            check("conf_ce1_b",  32'(FLASH_CE1_B), 32'd1);
            check("conf_prog_b", 32'(PROG_B),      32'd1);
            check("conf_err",    32'(CFG_ERR),     32'd0);
            check("conf_retry",  32'(RETRY_CNT),   32'(model_retry));
        end
    endtask

    function automatic int rnd_mode();
        int pick;
        pick = $urandom_range(4, 0);
        return (pick == 4) ? M_TIE : pick;
    endfunction

    initial begin
        model_img   = 2'b00;
        model_retry = 0;
        model_state = S_ICS;

        // 1. Nominal boot: headers 01, MAN_AUTO 0, INIT +10, DONE +20.
        set_hdr(2'b01);
        MAN_AUTO = 1'b0;
        do_reset(3);
        run_attempt(M_OK, 10, 20);

        // DONE falling while configured is ignored.
        FPGA_DONE = 1'b0;
        repeat (6) tick();
        check("done_drop_ignored", 32'(CFG_STATE), 32'(S_CONF));

        // 2. INIT timeout twice -> golden retry then ERROR.
        set_hdr(2'b01);
        press(5);
        run_attempt(M_INIT_TO, 0, 0);
        run_attempt(M_INIT_TO, 0, 0);
        repeat (5) tick();
        check("error_holds", 32'(CFG_STATE), 32'(S_ERR));

        // 3. CRC error then successful golden retry.
        set_hdr(2'($urandom_range(3, 0)));
        press(5);
        run_attempt(M_CRC, $urandom_range(20, 0), $urandom_range(40, 0));
        run_attempt(M_OK,  $urandom_range(20, 0), $urandom_range(40, 0));
        check("crc_then_ok_retry", 32'(RETRY_CNT), 32'd1);

        // 4. Debounce: short glitch ignored, full press restarts once.
        press($urandom_range(3, 1));
        repeat (8) tick();
        check("glitch_state", 32'(CFG_STATE), 32'(S_CONF));
        check("glitch_retry", 32'(RETRY_CNT), 32'd1);
        set_hdr(2'b11);
        press(5);
        run_attempt(M_OK, $urandom_range(20, 0), $urandom_range(40, 0));

        // 5. Corners: MAN_AUTO override, DONE/INIT tie, DONE timeout, reset.
        MAN_AUTO = 1'b1;
        set_hdr(2'b01);
        press(5);
        run_attempt(M_TIE, $urandom_range(20, 0), $urandom_range(40, 0));
        MAN_AUTO = 1'b0;
        press(4);
        run_attempt(M_DONE_TO, $urandom_range(20, 0), 0);
        run_attempt(M_RESET, $urandom_range(20, 0), $urandom_range(20, 0));
        run_attempt(M_OK, $urandom_range(20, 0), $urandom_range(40, 0));

        // Randomized sequences against the model.
        for (int it = 0; it < 8; it++) begin
            MAN_AUTO = 1'($urandom_range(1, 0));
            set_hdr(2'($urandom_range(3, 0)));
            press($urandom_range(5, 4));
            for (int a = 0; a < 3 && model_state == S_PROG; a++) begin
                run_attempt(rnd_mode(), $urandom_range(20, 0), $urandom_range(40, 0));
            end
            check("rand_final_state", 32'(CFG_STATE), 32'(model_state));
            check("rand_final_retry", 32'(RETRY_CNT), 32'(model_retry));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
